// File: rtl/sigmoid_pipelined.sv
// Four-stage fixed-point logistic sigmoid (PLAN piecewise-linear, odd symmetry).
// Q3.12 signed in, Q4.12 unsigned out, one sample per clock, no backpressure.
module sigmoid_pipelined (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] data_in,
    output logic        valid_out,
    output logic [15:0] data_out
);

    logic [3:0]  vld_q;
    logic        s1_q, s2_q;
    logic [14:0] a1_q, a_d;
    logic [12:0] y2_q, y_d;
    logic [12:0] r3_q, r_d;
    logic [15:0] out_q;
    logic [15:0] neg;

    // -8.0 has no positive Q3.12 twin; pin it to the largest magnitude instead.
    always_comb begin
        neg = 16'd0 - data_in;
        a_d = data_in[14:0];
        if (data_in == 16'h8000)
            a_d = 15'h7FFF;
        else if (data_in[15])
            a_d = neg[14:0];
    end

    always_comb begin
        y_d = 13'(a1_q >> 2) + 13'h0800;
        if (a1_q >= 15'h5000)
            y_d = 13'h1000;
        else if (a1_q >= 15'h2600)
            y_d = 13'(a1_q >> 5) + 13'h0D80;
        else if (a1_q >= 15'h1000)
            y_d = 13'(a1_q >> 3) + 13'h0A00;
    end

    always_comb begin
        r_d = y2_q;
        if (s2_q)
            r_d = 13'h1000 - y2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            s1_q  <= 1'b0;
            a1_q  <= '0;
            s2_q  <= 1'b0;
            y2_q  <= '0;
            r3_q  <= '0;
            out_q <= '0;
        end else begin
            vld_q <= {vld_q[2:0], valid_in};
            s1_q  <= data_in[15];
            a1_q  <= a_d;
            s2_q  <= s1_q;
            y2_q  <= y_d;
            r3_q  <= r_d;
            out_q <= {3'b000, r3_q};
        end
    end

    assign valid_out = vld_q[3];
    assign data_out  = out_q;

endmodule

// File: tb/tb_sigmoid_pipelined.sv
// Scoreboard bench for sigmoid_pipelined: driver pushes expected result and due
// cycle, an independent monitor pops and checks whenever valid_out is high.
module tb_sigmoid_pipelined;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        valid_out;
    logic [15:0] data_out;

    sigmoid_pipelined dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .data_in  (data_in),
        .valid_out(valid_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
        logic [15:0] din;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference from the segment equations, computed with integer arithmetic.
    function automatic logic [15:0] ref_sig(input logic [15:0] x);
        int v, a, y, r;
        v = $signed(x);
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        if (a >= 20480)      y = 4096;
        else if (a >= 9728)  y = a / 32 + 3456;
        else if (a >= 4096)  y = a / 8 + 2560;
        else                 y = a / 4 + 2048;
        r = (v < 0) ? 4096 - y : y;
        return 16'(r);
    endfunction

    task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] e);
        exp_t it;
        @(posedge clk);
        #1;
        valid_in = v;
        data_in  = d;
        if (v) begin
            it.data = e;
            it.due  = cyc + 4;
            it.din  = d;
            exp_q.push_back(it);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every valid_out must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        if (rst && valid_out) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: cycle %0d data 0x%0h, scoreboard empty", cyc, data_out);
            end else begin
                exp_t it;
                it = exp_q.pop_front();
                total++;
                if (data_out !== it.data || cyc != it.due) begin
                    bad++;
                    $display("FAIL result in=0x%0h: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                             it.din, data_out, cyc, it.data, it.due);
                end
                total++;
                if (data_out > 16'h1000) begin
                    bad++;
                    $display("FAIL range in=0x%0h: got 0x%0h above 0x1000", it.din, data_out);
                end
            end
        end
    end

    logic [15:0] seg_in  [11];
    logic [15:0] seg_out [11];
    logic [15:0] str_in  [4];
    logic [15:0] str_out [4];

    initial begin
        seg_in  = '{16'h0000, 16'h0800, 16'h1000, 16'h2600, 16'h5000, 16'h7FFF,
                    16'hF000, 16'hF800, 16'hDA00, 16'hB000, 16'h8000};
        seg_out = '{16'h0800, 16'h0A00, 16'h0C00, 16'h0EB0, 16'h1000, 16'h1000,
                    16'h0400, 16'h0600, 16'h0150, 16'h0000, 16'h0000};
        str_in  = '{16'h0000, 16'h1000, 16'hF000, 16'h5000};
        str_out = '{16'h0800, 16'h0C00, 16'h0400, 16'h1000};

        // Reset hold with live random stimulus: nothing may leak out.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            data_in  = 16'($urandom);
            @(negedge clk);
            check("reset_hold_valid", {31'd0, valid_out}, 32'd0);
            check("reset_hold_data", {16'd0, data_out}, 32'd0);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Segment points and negative/symmetry, each held for 5 cycles.
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < 5; k++) drive(1'b1, seg_in[i], seg_out[i]);
            drive(1'b0, seg_in[i], 16'h0);
        end
        for (int k = 0; k < 6; k++) drive(1'b0, 16'h0, 16'h0);

        // Back-to-back streaming.
        for (int i = 0; i < 4; i++) drive(1'b1, str_in[i], str_out[i]);
        for (int k = 0; k < 6; k++) drive(1'b0, 16'h0, 16'h0);

        // Valid gaps 1,0,1,1,0.
        drive(1'b1, 16'h0800, 16'h0A00);
        drive(1'b0, 16'h1234, 16'h0);
        drive(1'b1, 16'hF800, 16'h0600);
        drive(1'b1, 16'h2600, 16'h0EB0);
        drive(1'b0, 16'h4321, 16'h0);
        for (int k = 0; k < 6; k++) drive(1'b0, 16'h0, 16'h0);

        // Mid-stream reset with three samples in flight.
        drive(1'b1, 16'h1000, 16'h0C00);
        drive(1'b1, 16'h5000, 16'h1000);
        drive(1'b1, 16'h0800, 16'h0A00);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, valid_out}, 32'd0);
        check("async_reset_data", {16'd0, data_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) drive(1'b0, 16'h0, 16'h0);

        // First valid after release appears exactly 4 edges later.
        drive(1'b1, 16'hF000, 16'h0400);
        drive(1'b0, 16'h0, 16'h0);

        // Exhaustive sweep against the reference equations.
        for (int i = 0; i < 65536; i++) drive(1'b1, 16'(i), ref_sig(16'(i)));
        drive(1'b0, 16'h0, 16'h0);

        // Bounded drain.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
